// File: rtl/w_update_sched_if.sv
// Handshake bundle for the tap-weight update scheduler: host and adapt requesters,
// control strobes, and the registered weight-write port toward the FIR datapath.
interface w_update_sched_if #(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned D_W   = 2
);
  logic             host_valid;
  logic             host_ready;
  logic [IDX_W-1:0] host_idx;
  logic [D_W-1:0]   host_data;

  logic             adapt_valid;
  logic             adapt_ready;
  logic [IDX_W-1:0] adapt_idx;
  logic [D_W-1:0]   adapt_data;

  logic             freeze;
  logic             clear_req;
  logic             err_clr;

  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic [D_W-1:0]   upd_data;
  logic             busy;
  logic             clear_done;
  logic             err_idx;

  modport master (
    output host_valid, host_idx, host_data,
    output adapt_valid, adapt_idx, adapt_data,
    output freeze, clear_req, err_clr,
    input  host_ready, adapt_ready,
    input  upd_valid, upd_idx, upd_data, busy, clear_done, err_idx
  );

  modport slave (
    input  host_valid, host_idx, host_data,
    input  adapt_valid, adapt_idx, adapt_data,
    input  freeze, clear_req, err_clr,
    output host_ready, adapt_ready,
    output upd_valid, upd_idx, upd_data, busy, clear_done, err_idx
  );
endinterface

// File: rtl/w_update_sched.sv
// Tap-weight write scheduler: arbitrates host and LMS-adapt writes with a bounded host
// burst, and runs a self-timed clear sweep over all taps. One registered write per cycle.
module w_update_sched #(
  parameter int unsigned   N              = 1008,
  parameter int unsigned   IDX_W          = $clog2(N),
  parameter int unsigned   D_W            = 2,
  parameter logic [D_W-1:0] CLEAR_VAL     = '0,
  parameter int unsigned   MAX_HOST_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  w_update_sched_if.slave   bus
);

  localparam int unsigned BurstW = (MAX_HOST_BURST > 0) ? $clog2(MAX_HOST_BURST + 1) : 1;
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_HOST_BURST);
  localparam logic [IDX_W:0]    IdxLimit = (IDX_W + 1)'(N);
  localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(N - 1);

  typedef enum logic [0:0] {StArb, StSweep} state_e;

  state_e            state_q;
  logic [BurstW-1:0] burst_q;
  logic [IDX_W-1:0]  sweep_q;
  logic              upd_valid_q;
  logic [IDX_W-1:0]  upd_idx_q;
  logic [D_W-1:0]    upd_data_q;
  logic              busy_q;
  logic              clear_done_q;
  logic              err_q;

  logic in_arb;
  logic adapt_elig;
  logic force_adapt;
  logic host_ready;
  logic adapt_ready;
  logic host_go;
  logic adapt_go;
  logic host_bad;
  logic adapt_bad;

  // Clear request pre-empts both requesters in the very cycle it is raised.
  always_comb begin
    in_arb      = (state_q == StArb) && !bus.clear_req;
    adapt_elig  = bus.adapt_valid && !bus.freeze;
    force_adapt = adapt_elig && (burst_q == BurstMax);
    host_ready  = in_arb && !force_adapt;
    adapt_ready = in_arb && !bus.freeze && (!bus.host_valid || force_adapt);
    host_go     = bus.host_valid && host_ready;
    adapt_go    = bus.adapt_valid && adapt_ready;
    host_bad    = {1'b0, bus.host_idx} >= IdxLimit;
    adapt_bad   = {1'b0, bus.adapt_idx} >= IdxLimit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StArb;
      burst_q      <= '0;
      sweep_q      <= '0;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= '0;
      upd_data_q   <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      upd_valid_q  <= 1'b0;
      clear_done_q <= 1'b0;

      if (bus.err_clr) begin
        err_q <= 1'b0;
      end
      // A new out-of-range grant wins over a simultaneous clear.
      if ((host_go && host_bad) || (adapt_go && adapt_bad)) begin
        err_q <= 1'b1;
      end

      if (adapt_go || !adapt_elig) begin
        burst_q <= '0;
      end else if (host_go && (burst_q != BurstMax)) begin
        burst_q <= burst_q + 1'b1;
      end

      unique case (state_q)
        StArb: begin
          if (bus.clear_req) begin
            state_q <= StSweep;
            busy_q  <= 1'b1;
            sweep_q <= '0;
          end else if (host_go) begin
            if (!host_bad) begin
              upd_valid_q <= 1'b1;
              upd_idx_q   <= bus.host_idx;
              upd_data_q  <= bus.host_data;
            end
          end else if (adapt_go) begin
            if (!adapt_bad) begin
              upd_valid_q <= 1'b1;
              upd_idx_q   <= bus.adapt_idx;
              upd_data_q  <= bus.adapt_data;
            end
          end
        end
        StSweep: begin
          upd_valid_q <= 1'b1;
          upd_idx_q   <= sweep_q;
          upd_data_q  <= CLEAR_VAL;
          if (sweep_q == LastIdx) begin
            state_q      <= StArb;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign bus.host_ready  = host_ready;
  assign bus.adapt_ready = adapt_ready;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_idx     = upd_idx_q;
  assign bus.upd_data    = upd_data_q;
  assign bus.busy        = busy_q;
  assign bus.clear_done  = clear_done_q;
  assign bus.err_idx     = err_q;

endmodule

// File: tb/tb_w_update_sched.sv
// Bench for w_update_sched (N=8): per-cycle comparison against a queue-free integer model
// of the scheduling rules, plus directed scenarios with literal expectations.
module tb_w_update_sched;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned D_W   = 2;
  localparam int unsigned MAXB  = 4;
  localparam int unsigned CLRV  = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  w_update_sched_if #(.IDX_W(IDX_W), .D_W(D_W)) bus ();

  w_update_sched #(
    .N(N), .IDX_W(IDX_W), .D_W(D_W), .CLEAR_VAL(2'(CLRV)), .MAX_HOST_BURST(MAXB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: sweep_pos is the next tap to clear (-1 when not sweeping),
  // run counts host wins while adapt is waiting.
  int   sweep_pos = -1;
  int   run       = 0;
  logic m_valid   = 1'b0;
  int   m_idx     = 0;
  int   m_data    = 0;
  logic m_cd      = 1'b0;
  logic m_err     = 1'b0;

  function automatic void m_ready(output logic hr, output logic ar);
    logic open_arb, elig, starve;
    open_arb = (sweep_pos < 0) && !bus.clear_req;
    elig     = bus.adapt_valid && !bus.freeze;
    starve   = elig && (run == int'(MAXB));
    hr = open_arb && !starve;
    ar = open_arb && !bus.freeze && (!bus.host_valid || starve);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sweep_pos = -1; run = 0; m_valid = 1'b0; m_idx = 0; m_data = 0;
      m_cd = 1'b0; m_err = 1'b0;
    end else begin
      logic hr, ar, hg, ag, elig, nv, ncd, nerr;
      m_ready(hr, ar);
      hg   = bus.host_valid && hr;
      ag   = bus.adapt_valid && ar;
      elig = bus.adapt_valid && !bus.freeze;
      nv = 1'b0; ncd = 1'b0; nerr = m_err && !bus.err_clr;
      if (sweep_pos >= 0) begin
        nv = 1'b1; m_idx = sweep_pos; m_data = int'(CLRV);
        if (sweep_pos == int'(N) - 1) begin ncd = 1'b1; sweep_pos = -1; end
        else sweep_pos++;
      end else if (bus.clear_req) begin
        sweep_pos = 0;
      end else if (hg) begin
        if (int'(bus.host_idx) < int'(N)) begin
          nv = 1'b1; m_idx = int'(bus.host_idx); m_data = int'(bus.host_data);
        end else nerr = 1'b1;
      end else if (ag) begin
        if (int'(bus.adapt_idx) < int'(N)) begin
          nv = 1'b1; m_idx = int'(bus.adapt_idx); m_data = int'(bus.adapt_data);
        end else nerr = 1'b1;
      end
      if (ag || !elig) run = 0;
      else if (hg && run < int'(MAXB)) run++;
      m_valid = nv; m_cd = ncd; m_err = nerr;
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      logic hr, ar;
      m_ready(hr, ar);
      chk("mon_host_ready", 32'(bus.host_ready), 32'(hr));
      chk("mon_adapt_ready", 32'(bus.adapt_ready), 32'(ar));
      chk("mon_upd_valid", 32'(bus.upd_valid), 32'(m_valid));
      if (m_valid) begin
        chk("mon_upd_idx", 32'(bus.upd_idx), 32'(m_idx));
        chk("mon_upd_data", 32'(bus.upd_data), 32'(m_data));
      end
      chk("mon_busy", 32'(bus.busy), 32'(sweep_pos >= 0));
      chk("mon_clear_done", 32'(bus.clear_done), 32'(m_cd));
      chk("mon_err_idx", 32'(bus.err_idx), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] pat, busy_m, val_m, cd_m, hr_m;
    int nval, cnt_a, cnt_v, found;
    logic idx_ok;

    bus.host_valid = 0; bus.host_idx = '0; bus.host_data = '0;
    bus.adapt_valid = 0; bus.adapt_idx = '0; bus.adapt_data = '0;
    bus.freeze = 0; bus.clear_req = 0; bus.err_clr = 0;

    @(negedge clock);
    chk("rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("rst_upd_idx", 32'(bus.upd_idx), 0);
    chk("rst_upd_data", 32'(bus.upd_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_clear_done", 32'(bus.clear_done), 0);
    chk("rst_err_idx", 32'(bus.err_idx), 0);
    tick();
    reset = 0;
    mon_en = 1;
    tick();

    // 1: single host write
    bus.host_valid = 1; bus.host_idx = 5; bus.host_data = 2;
    @(negedge clock);
    chk("t1_host_ready", 32'(bus.host_ready), 1);
    tick();
    bus.host_valid = 0;
    @(negedge clock);
    chk("t1_upd_valid", 32'(bus.upd_valid), 1);
    chk("t1_upd_idx", 32'(bus.upd_idx), 5);
    chk("t1_upd_data", 32'(bus.upd_data), 2);
    tick();
    @(negedge clock);
    chk("t1_upd_idle", 32'(bus.upd_valid), 0);
    tick();

    // 2: contention, expect H,H,H,H,A repeating
    bus.host_valid = 1; bus.host_idx = 1; bus.host_data = 1;
    bus.adapt_valid = 1; bus.adapt_idx = 2; bus.adapt_data = 3;
    pat = '0; nval = 0;
    for (int k = 0; k < 21; k++) begin
      if (k == 20) begin bus.host_valid = 0; bus.adapt_valid = 0; end
      @(negedge clock);
      if (k >= 1 && bus.upd_valid) begin
        nval++;
        if (bus.upd_idx == 2) pat[k-1] = 1'b1;
      end
      tick();
    end
    chk("t2_grant_pattern", pat, 32'h0008_4210);
    chk("t2_write_count", 32'(nval), 20);

    // 3: freeze blocks adapt
    bus.freeze = 1; bus.adapt_valid = 1; bus.adapt_idx = 3; bus.adapt_data = 1;
    cnt_a = 0; cnt_v = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      cnt_a += int'(bus.adapt_ready);
      cnt_v += int'(bus.upd_valid);
      tick();
    end
    chk("t3_frozen_ready", 32'(cnt_a), 0);
    chk("t3_frozen_writes", 32'(cnt_v), 0);
    bus.freeze = 0;
    @(negedge clock);
    chk("t3_thaw_ready", 32'(bus.adapt_ready), 1);
    tick();
    bus.adapt_valid = 0;
    @(negedge clock);
    chk("t3_upd_valid", 32'(bus.upd_valid), 1);
    chk("t3_upd_idx", 32'(bus.upd_idx), 3);
    chk("t3_upd_data", 32'(bus.upd_data), 1);
    tick();
    tick();

    // 4: clear sweep with host held
    bus.host_valid = 1; bus.host_idx = 6; bus.host_data = 2; bus.clear_req = 1;
    busy_m = '0; val_m = '0; cd_m = '0; hr_m = '0; idx_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      busy_m[k] = bus.busy;
      val_m[k]  = bus.upd_valid;
      cd_m[k]   = bus.clear_done;
      hr_m[k]   = bus.host_ready;
      if (k >= 2 && k <= 9 &&
          (int'(bus.upd_idx) != k - 2 || int'(bus.upd_data) != int'(CLRV))) idx_ok = 1'b0;
      tick();
      bus.clear_req = 0;
    end
    bus.host_valid = 0;
    chk("t4_busy_cycles", busy_m, 32'h0000_01FE);
    chk("t4_write_cycles", val_m, 32'h0000_0FFC);
    chk("t4_clear_done", cd_m, 32'h0000_0200);
    chk("t4_host_ready", hr_m, 32'h0000_0E00);
    chk("t4_sweep_idx_data", 32'(idx_ok), 1);
    tick();
    tick();

    // 5: out-of-range index
    bus.host_valid = 1; bus.host_idx = 4'(N); bus.host_data = 3;
    @(negedge clock);
    chk("t5_host_ready", 32'(bus.host_ready), 1);
    tick();
    bus.host_valid = 0;
    @(negedge clock);
    chk("t5_no_write", 32'(bus.upd_valid), 0);
    chk("t5_err_set", 32'(bus.err_idx), 1);
    tick(); tick();
    @(negedge clock);
    chk("t5_err_held", 32'(bus.err_idx), 1);
    tick();
    bus.err_clr = 1;
    tick();
    bus.err_clr = 0;
    @(negedge clock);
    chk("t5_err_cleared", 32'(bus.err_idx), 0);
    tick();

    // 6: reset during sweep
    bus.clear_req = 1;
    tick();
    bus.clear_req = 0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clock);
      if (bus.upd_valid && bus.upd_idx == 3) found = 1;
      else tick();
    end
    chk("t6_reached_idx3", 32'(found), 1);
    #2;
    reset = 1;
    #1;
    chk("t6_rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("t6_rst_upd_idx", 32'(bus.upd_idx), 0);
    chk("t6_rst_upd_data", 32'(bus.upd_data), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_clear_done", 32'(bus.clear_done), 0);
    tick();
    reset = 0;
    cnt_v = 0; cnt_a = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      cnt_v += int'(bus.upd_valid);
      cnt_a += int'(bus.busy) + int'(bus.clear_done);
      tick();
    end
    chk("t6_no_writes", 32'(cnt_v), 0);
    chk("t6_no_busy_done", 32'(cnt_a), 0);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
